// File: rtl/axis_extract_pkg.sv
// Shared widths, FSM state type, beat struct and keep popcount for the dest extractor.
package axis_extract_pkg;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int DEST_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic {HEAD, BODY} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } beat_t;

  function automatic logic [3:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid for payload beats; 1-cycle latency when empty.
// 'room' is a flop reporting at most one entry held, so upstream ready never sees out_rdy combinationally.
module axis_skid_buffer
  import axis_extract_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  beat_t in_dat,
  output logic  out_vld,
  output beat_t out_dat,
  input  logic  out_rdy,
  output logic  room
);
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic [1:0] wr_idx;
  logic       pop;
  beat_t      ent0;
  beat_t      ent1;

  assign out_vld = (cnt != 2'd0);
  assign out_dat = ent0;
  assign pop     = out_vld && out_rdy;
  assign wr_idx  = cnt - {1'b0, pop};

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (pop && !push) cnt_nxt = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= 2'd0;
      room <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      room <= (cnt_nxt <= 2'd1);
    end
  end

  // Shift on pop first; a same-cycle push lands behind whatever remains.
  always_ff @(posedge clk) begin
    if (pop) ent0 <= ent1;
    if (push) begin
      if (wr_idx == 2'd0) ent0 <= in_dat;
      else                ent1 <= in_dat;
    end
  end
endmodule

// File: rtl/axis_dest_extractor.sv
// Splits routed AXIS packets into a payload stream and a one-beat-per-packet tdest stream.
// AXIS_EXTRACT_LEN_EN adds a saturating byte-length count on m_addr_axis_tuser.
module axis_dest_extractor
  import axis_extract_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_packet_axis_tdata,
  input  logic [KEEP_W-1:0] s_packet_axis_tkeep,
  input  logic              s_packet_axis_tlast,
  input  logic [DEST_W-1:0] s_packet_axis_tdest,
  input  logic              s_packet_axis_tvalid,
  output logic              s_packet_axis_tready,
  output logic [DATA_W-1:0] m_packet_axis_tdata,
  output logic [KEEP_W-1:0] m_packet_axis_tkeep,
  output logic              m_packet_axis_tlast,
  output logic              m_packet_axis_tvalid,
  input  logic              m_packet_axis_tready,
  output logic [DEST_W-1:0] m_addr_axis_tdata,
  output logic              m_addr_axis_tlast,
`ifdef AXIS_EXTRACT_LEN_EN
  output logic [LEN_W-1:0]  m_addr_axis_tuser,
`endif
  output logic              m_addr_axis_tvalid,
  input  logic              m_addr_axis_tready
);
  state_t            state_r;
  state_t            state_nxt;
  logic [DEST_W-1:0] dest_r;
  logic [DEST_W-1:0] head_dest;
  logic              addr_vld_r;
  logic [DEST_W-1:0] addr_dat_r;
  logic              room;
  logic              accept;
  beat_t             in_beat;
  beat_t             out_beat;

  // Only one address beat may be outstanding; a draining one frees the slot this cycle.
  assign s_packet_axis_tready = room && (!addr_vld_r || m_addr_axis_tready);
  assign accept    = s_packet_axis_tvalid && s_packet_axis_tready;
  assign head_dest = (state_r == HEAD) ? s_packet_axis_tdest : dest_r;

  always_comb begin
    state_nxt = state_r;
    if (accept) state_nxt = s_packet_axis_tlast ? HEAD : BODY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= HEAD;
      dest_r     <= '0;
      addr_vld_r <= 1'b0;
      addr_dat_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (accept && state_r == HEAD) dest_r <= s_packet_axis_tdest;
      if (accept && s_packet_axis_tlast) begin
        addr_vld_r <= 1'b1;
        addr_dat_r <= head_dest;
      end else if (m_addr_axis_tready) begin
        addr_vld_r <= 1'b0;
      end
    end
  end

  assign m_addr_axis_tvalid = addr_vld_r;
  assign m_addr_axis_tdata  = addr_dat_r;
  assign m_addr_axis_tlast  = 1'b1;

`ifdef AXIS_EXTRACT_LEN_EN
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] len_base;
  logic [LEN_W-1:0] len_sat;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] addr_len_r;

  always_comb begin
    len_base = (state_r == HEAD) ? '0 : len_r;
    len_sum  = {1'b0, len_base} + {{(LEN_W-3){1'b0}}, keep_popcount(s_packet_axis_tkeep)};
    len_sat  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_r      <= '0;
      addr_len_r <= '0;
    end else if (accept) begin
      len_r <= len_sat;
      if (s_packet_axis_tlast) addr_len_r <= len_sat;
    end
  end

  assign m_addr_axis_tuser = addr_len_r;
`endif

  assign in_beat = '{tdata: s_packet_axis_tdata, tkeep: s_packet_axis_tkeep,
                     tlast: s_packet_axis_tlast};

  axis_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .in_dat  (in_beat),
    .out_vld (m_packet_axis_tvalid),
    .out_dat (out_beat),
    .out_rdy (m_packet_axis_tready),
    .room    (room)
  );

  assign m_packet_axis_tdata = out_beat.tdata;
  assign m_packet_axis_tkeep = out_beat.tkeep;
  assign m_packet_axis_tlast = out_beat.tlast;
endmodule

// File: tb/tb_axis_dest_extractor.sv
// Scoreboard bench for axis_dest_extractor: randomized packets against a packet-level model.
module tb_axis_dest_extractor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_packet_axis_tdata = '0;
  logic [7:0]  s_packet_axis_tkeep = '0;
  logic        s_packet_axis_tlast = 1'b0;
  logic [31:0] s_packet_axis_tdest = '0;
  logic        s_packet_axis_tvalid = 1'b0;
  logic        s_packet_axis_tready;
  logic [63:0] m_packet_axis_tdata;
  logic [7:0]  m_packet_axis_tkeep;
  logic        m_packet_axis_tlast;
  logic        m_packet_axis_tvalid;
  logic        m_packet_axis_tready = 1'b1;
  logic [31:0] m_addr_axis_tdata;
  logic        m_addr_axis_tlast;
`ifdef AXIS_EXTRACT_LEN_EN
  logic [15:0] m_addr_axis_tuser;
`endif
  logic        m_addr_axis_tvalid;
  logic        m_addr_axis_tready = 1'b1;

  always #5 clk = ~clk;

  axis_dest_extractor dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_packet_axis_tdata  (s_packet_axis_tdata),
    .s_packet_axis_tkeep  (s_packet_axis_tkeep),
    .s_packet_axis_tlast  (s_packet_axis_tlast),
    .s_packet_axis_tdest  (s_packet_axis_tdest),
    .s_packet_axis_tvalid (s_packet_axis_tvalid),
    .s_packet_axis_tready (s_packet_axis_tready),
    .m_packet_axis_tdata  (m_packet_axis_tdata),
    .m_packet_axis_tkeep  (m_packet_axis_tkeep),
    .m_packet_axis_tlast  (m_packet_axis_tlast),
    .m_packet_axis_tvalid (m_packet_axis_tvalid),
    .m_packet_axis_tready (m_packet_axis_tready),
    .m_addr_axis_tdata    (m_addr_axis_tdata),
    .m_addr_axis_tlast    (m_addr_axis_tlast),
`ifdef AXIS_EXTRACT_LEN_EN
    .m_addr_axis_tuser    (m_addr_axis_tuser),
`endif
    .m_addr_axis_tvalid   (m_addr_axis_tvalid),
    .m_addr_axis_tready   (m_addr_axis_tready)
  );

  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} pay_t;
  typedef struct {logic [31:0] dest; int len;} adr_t;

  pay_t        pay_q[$];
  adr_t        adr_q[$];
  pay_t        mon_p;
  adr_t        mon_a;
  logic [7:0]  pk_keep[$];
  logic [31:0] pk_dest[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          bp = 1'b0;
  bit          pkt_force = 1'b1;
  bit          addr_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready generator runs after the driver at each edge so both see settled values.
  initial forever begin
    @(posedge clk);
    #2;
    m_packet_axis_tready = bp ? 1'($urandom_range(0, 1)) : pkt_force;
    m_addr_axis_tready   = bp ? ($urandom_range(0, 3) != 0) : addr_force;
  end

  always @(negedge clk) begin
    if (rst && m_packet_axis_tvalid && m_packet_axis_tready) begin
      if (pay_q.size() == 0) check("pay_unexpected", 1, 0);
      else begin
        mon_p = pay_q.pop_front();
        check("pay_data", m_packet_axis_tdata, mon_p.d);
        check("pay_keep", m_packet_axis_tkeep, mon_p.k);
        check("pay_last", m_packet_axis_tlast, mon_p.l);
      end
    end
    if (rst && m_addr_axis_tvalid && m_addr_axis_tready) begin
      if (adr_q.size() == 0) check("addr_unexpected", 1, 0);
      else begin
        mon_a = adr_q.pop_front();
        check("addr_dest", m_addr_axis_tdata, mon_a.dest);
        check("addr_tlast", m_addr_axis_tlast, 1);
`ifdef AXIS_EXTRACT_LEN_EN
        check("addr_len", m_addr_axis_tuser, 64'(mon_a.len));
`endif
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [31:0] dst, input bit expect_out, output bit ok);
    bit acc;
    ok = 1'b0;
    s_packet_axis_tdata  = d;
    s_packet_axis_tkeep  = k;
    s_packet_axis_tlast  = l;
    s_packet_axis_tdest  = dst;
    s_packet_axis_tvalid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = s_packet_axis_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    s_packet_axis_tvalid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
    else if (expect_out) pay_q.push_back('{d, k, l});
  endtask

  // Model: address = first-beat tdest, length = total set keep bits clamped to 16 bits.
  task automatic send_pkt();
    int sum;
    bit ok;
    sum = 0;
    for (int i = 0; i < pk_keep.size(); i++) begin
      drive_beat({$urandom, $urandom}, pk_keep[i], i == pk_keep.size() - 1, pk_dest[i], 1'b1, ok);
      if (!ok) return;
      sum += $countones(pk_keep[i]);
    end
    adr_q.push_back('{pk_dest[0], (sum > 65535) ? 65535 : sum});
  endtask

  task automatic drain();
    for (int c = 0; c < 1000 && (pay_q.size() != 0 || adr_q.size() != 0); c++) @(posedge clk);
    #1;
    check("drain_pay", pay_q.size(), 0);
    check("drain_addr", adr_q.size(), 0);
  endtask

  initial begin
    bit ok;
    logic [31:0] d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_packet_axis_tready, 0);
    check("rst_pay_vld", m_packet_axis_tvalid, 0);
    check("rst_addr_vld", m_addr_axis_tvalid, 0);
    check("rst_addr_dat", m_addr_axis_tdata, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", s_packet_axis_tready, 1);

    // Single-beat packet: payload and address both visible one cycle after accept.
    pk_keep = '{8'hFF};
    pk_dest = '{32'h5};
    send_pkt();
    check("lat_pay_vld", m_packet_axis_tvalid, 1);
    check("lat_addr_vld", m_addr_axis_tvalid, 1);
    drain();

    pk_keep = '{8'hFF, 8'hFF, 8'h0F};
    pk_dest = '{32'hA, 32'hB, 32'hB};
    send_pkt();
    drain();

    // Address consumer stalls: the next packet must wait and the address must hold.
    addr_force = 1'b0;
    @(posedge clk);
    #3;
    pk_keep = '{8'h3F, 8'h01};
    pk_dest = '{32'h11, 32'h99};
    send_pkt();
    d0 = 32'h22;
    s_packet_axis_tdata  = 64'h1234;
    s_packet_axis_tkeep  = 8'hFF;
    s_packet_axis_tlast  = 1'b1;
    s_packet_axis_tdest  = d0;
    s_packet_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_s_tready", s_packet_axis_tready, 0);
      check("stall_addr_vld", m_addr_axis_tvalid, 1);
      check("stall_addr_dat", m_addr_axis_tdata, 32'h11);
      @(posedge clk);
      #1;
    end
    addr_force = 1'b1;
    pk_keep = '{8'hFF};
    pk_dest = '{d0};
    send_pkt();
    drain();

    bp = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int nb;
      nb = $urandom_range(1, 5);
      pk_keep.delete();
      pk_dest.delete();
      for (int i = 0; i < nb; i++) begin
        pk_keep.push_back(8'($urandom_range(1, 255)));
        pk_dest.push_back($urandom);
      end
      send_pkt();
    end
    bp = 1'b0;
    drain();

    // Reset after the first beat of a 4-beat packet; the next beat must start a fresh head.
    pkt_force = 1'b0;
    @(posedge clk);
    #3;
    drive_beat(64'hDEAD, 8'hFF, 1'b0, 32'h99, 1'b0, ok);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_pay_vld", m_packet_axis_tvalid, 0);
    check("midrst_addr_vld", m_addr_axis_tvalid, 0);
    check("midrst_s_tready", s_packet_axis_tready, 0);
    pkt_force = 1'b1;
    pk_keep = '{8'hFF, 8'h01};
    pk_dest = '{32'h7, 32'h55};
    send_pkt();
    drain();

    pk_keep.delete();
    pk_dest.delete();
    for (int i = 0; i < 8200; i++) begin
      pk_keep.push_back(8'hFF);
      pk_dest.push_back(32'hC0FFEE);
    end
    send_pkt();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
